// File: rtl/tdm_demux_rx_pkg.sv
// tdm_demux_rx_pkg
//   Shared constants for the two-channel TDM receiver: FSM state encoding,
//   default word width and channel indices into the overrun vector.
package tdm_demux_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV_A = 2'd1,
    RECV_B = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  localparam int CH_A = 0;
  localparam int CH_B = 1;

endpackage

// File: rtl/tdm_demux_rx_if.sv
// tdm_demux_rx_if
//   Bundles the serial input side and both channel output handshakes.
//   Ports (slave = receiver view):
//     din, din_valid, sof       serial bit, qualifier, start of frame (in)
//     sel                       slot being received, 0 = A, 1 = B (out)
//     out_a/valid_a/ack_a       channel A word + handshake
//     out_b/valid_b/ack_b       channel B word + handshake
//     frame_err                 one-cycle pulse on an aborted frame (out)
//     overrun                   sticky overwrite flags {B, A} (out)
interface tdm_demux_rx_if
  import tdm_demux_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             din;
  logic             din_valid;
  logic             sof;
  logic             sel;
  logic [WIDTH-1:0] out_a;
  logic             valid_a;
  logic             ack_a;
  logic [WIDTH-1:0] out_b;
  logic             valid_b;
  logic             ack_b;
  logic             frame_err;
  logic [1:0]       overrun;

  modport master (
    output din, din_valid, sof, ack_a, ack_b,
    input  sel, out_a, valid_a, out_b, valid_b, frame_err, overrun
  );

  modport slave (
    input  din, din_valid, sof, ack_a, ack_b,
    output sel, out_a, valid_a, out_b, valid_b, frame_err, overrun
  );
endinterface

// File: rtl/tdm_word_reg.sv
// tdm_word_reg
//   Per-channel output register with valid/ack handshake and sticky overrun.
//   Ports:
//     clk, reset   clock, async active-high reset
//     i_load       completed word available this cycle
//     i_word       the completed word
//     i_ack        consumer takes o_out (ignored while o_valid is low)
//     o_out        last completed word
//     o_valid      o_out holds an unconsumed word
//     o_overrun    set when a word is overwritten before being acked
module tdm_word_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_out,
  output logic             o_valid,
  output logic             o_overrun
);
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_load) begin
      // A new word wins over a same-cycle ack; only an unacked word counts as lost.
      r_out   <= i_word;
      r_valid <= 1'b1;
      if (r_valid && !i_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (i_ack && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out     = r_out;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx
//   Receive end of a two-slot TDM serial link. Deserializes LSB-first words,
//   A slot then B slot, and hands each to its channel register.
//   Ports:
//     clk, reset   clock, async active-high reset
//     bus          tdm_demux_rx_if slave modport (serial in, channel outputs)
//
//   state  | meaning
//   IDLE   | waiting for sof; bits without sof are dropped
//   RECV_A | assembling the channel A word
//   RECV_B | assembling the channel B word (sel = 1)
module tdm_demux_rx
  import tdm_demux_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  tdm_demux_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_frame_err;
  logic             w_early_sof;
  logic             w_load_a, w_load_b;
  logic             w_last;
  logic             w_ovr_a, w_ovr_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_early_sof;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_early_sof = 1'b0;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_last      = (r_cnt == CW'(WIDTH - 1));
    if (bus.din_valid) begin
      if (bus.sof) begin
        // sof always restarts at A bit0, dropping any partial word.
        w_early_sof    = (r_state != IDLE);
        w_state_nxt    = RECV_A;
        w_cnt_nxt      = CW'(1);
        w_shift_nxt    = '0;
        w_shift_nxt[0] = bus.din;
      end else if (r_state != IDLE) begin
        w_shift_nxt[r_cnt] = bus.din;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_load_a    = (r_state == RECV_A);
          w_load_b    = (r_state == RECV_B);
          w_state_nxt = (r_state == RECV_A) ? RECV_B : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.sel       = (r_state == RECV_B);
    bus.frame_err = r_frame_err;
  end

  // The word presented on load already includes the bit sampled this cycle.
  tdm_word_reg #(.WIDTH(WIDTH)) u_word_a (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load_a),
    .i_word    (w_shift_nxt),
    .i_ack     (bus.ack_a),
    .o_out     (bus.out_a),
    .o_valid   (bus.valid_a),
    .o_overrun (w_ovr_a)
  );

  tdm_word_reg #(.WIDTH(WIDTH)) u_word_b (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load_b),
    .i_word    (w_shift_nxt),
    .i_ack     (bus.ack_b),
    .o_out     (bus.out_b),
    .o_valid   (bus.valid_b),
    .o_overrun (w_ovr_b)
  );

  always_comb begin
    bus.overrun       = 2'b00;
    bus.overrun[CH_A] = w_ovr_a;
    bus.overrun[CH_B] = w_ovr_b;
  end
endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx
//   Directed frames for tdm_demux_rx (WIDTH = 4). Expected words and the
//   cycle they must appear in are queued when the frame is driven; a monitor
//   pops an entry whenever a channel presents a word.
module tb_tdm_demux_rx;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] word;
    int           stamp;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_rx_if #(.WIDTH(W)) bus ();
  tdm_demux_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   ferr_cyc  = -1;
  int   last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] word, input int stamp);
    exp_t e;
    e.word  = word;
    e.stamp = stamp;
    if (ch == 0) qa.push_back(e);
    else         qb.push_back(e);
  endtask

  task automatic present(input int ch, input logic [W-1:0] got);
    exp_t e;
    if (ch == 0) begin
      chk("word_a_expected", 32'(qa.size() > 0), 32'(1));
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("out_a", 32'(got), 32'(e.word));
        chk("latency_a", 32'(cyc), 32'(e.stamp));
      end
    end else begin
      chk("word_b_expected", 32'(qb.size() > 0), 32'(1));
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("out_b", 32'(got), 32'(e.word));
        chk("latency_b", 32'(cyc), 32'(e.stamp));
      end
    end
  endtask

  // Monitor: a word is presented when valid rises, the held word changes,
  // or valid stays high across an edge where the previous word was acked.
  logic         tk_a = 1'b0, tk_b = 1'b0;
  logic         pv_a = 1'b0, pv_b = 1'b0;
  logic [W-1:0] po_a = '0, po_b = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tk_a <= 1'b0;
      tk_b <= 1'b0;
    end else begin
      tk_a <= bus.ack_a & bus.valid_a;
      tk_b <= bus.ack_b & bus.valid_b;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pv_a = 1'b0; pv_b = 1'b0;
      po_a = '0;   po_b = '0;
    end else begin
      chk("frame_err", 32'(bus.frame_err), 32'(cyc == ferr_cyc));
      if (bus.valid_a && (!pv_a || bus.out_a != po_a || tk_a)) present(0, bus.out_a);
      if (bus.valid_b && (!pv_b || bus.out_b != po_b || tk_b)) present(1, bus.out_b);
      pv_a = bus.valid_a; po_a = bus.out_a;
      pv_b = bus.valid_b; po_b = bus.out_b;
    end
  end

  task automatic send_bit(input logic d, input logic s, input logic esel, input logic acka = 1'b0);
    @(negedge clk);
    chk("sel", 32'(bus.sel), 32'(esel));
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.sof       = s;
    bus.ack_a     = acka;
    bus.ack_b     = 1'b0;
    last_edge     = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.ack_a     = 1'b0;
      bus.ack_b     = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic ack_b_pulse();
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.ack_a     = 1'b0;
    bus.ack_b     = 1'b1;
    @(posedge clk);
  endtask

  // abort: sof lands in RECV_B, so sel reads 1 on that bit and frame_err follows.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic abort = 1'b0, input logic ack_last_a = 1'b0);
    int t;
    t = 0;
    for (int i = 0; i < W; i++) begin
      send_bit(a[i], i == 0, (i == 0) ? abort : 1'b0, (i == W - 1) ? ack_last_a : 1'b0);
      if (i == 0) begin
        t = last_edge;
        if (abort) ferr_cyc = t;
        push(0, a, t + W - 1);
        push(1, b, t + 2 * W - 1);
      end
    end
    for (int i = 0; i < W; i++) send_bit(b[i], 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    chk("qa_drained", 32'(qa.size()), 32'(0));
    chk("qb_drained", 32'(qb.size()), 32'(0));
    @(negedge clk);
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.ack_a     = 1'b0;
    bus.ack_b     = 1'b0;
    ferr_cyc      = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_a"},   32'(bus.out_a),     32'(0));
    chk({tag, "_out_b"},   32'(bus.out_b),     32'(0));
    chk({tag, "_valid_a"}, 32'(bus.valid_a),   32'(0));
    chk({tag, "_valid_b"}, 32'(bus.valid_b),   32'(0));
    chk({tag, "_sel"},     32'(bus.sel),       32'(0));
    chk({tag, "_ferr"},    32'(bus.frame_err), 32'(0));
    chk({tag, "_overrun"}, 32'(bus.overrun),   32'(0));
  endtask

  initial begin
    int t0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.ack_a     = 1'b0;
    bus.ack_b     = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal frame: A = 4'hA, B = 4'h3
    send_frame(4'hA, 4'h3);
    idle(2);
    #1;
    chk("nom_valid_a", 32'(bus.valid_a), 32'(1));
    chk("nom_valid_b", 32'(bus.valid_b), 32'(1));
    chk("nom_overrun", 32'(bus.overrun), 32'(0));

    // Stall of 3 cycles between bits 2 and 3 pushes both words 3 cycles later
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0);
    t0 = last_edge;
    push(0, 4'hA, t0 + 6);
    push(1, 4'h3, t0 + 10);
    send_bit(1'b1, 1'b0, 1'b0);
    idle(3);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    idle(2);

    // Early sof on bit 6: B word of the first frame never appears
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0);
    t0 = last_edge;
    push(0, 4'hA, t0 + 3);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_frame(4'hF, 4'h0, 1'b1);
    idle(2);
    #1;
    chk("esof_out_a", 32'(bus.out_a), 32'hF);
    chk("esof_out_b", 32'(bus.out_b), 32'h0);
    chk("esof_valid_b", 32'(bus.valid_b), 32'(1));
    chk("esof_overrun", 32'(bus.overrun), 32'b01);

    // Two frames, A never acked: overrun[0] set, second A word held
    do_reset();
    send_frame(4'hA, 4'h3);
    ack_b_pulse();
    send_frame(4'h5, 4'hC);
    idle(2);
    #1;
    chk("ovr_overrun", 32'(bus.overrun), 32'b01);
    chk("ovr_out_a", 32'(bus.out_a), 32'h5);
    chk("ovr_valid_a", 32'(bus.valid_a), 32'(1));

    // Same, but ack_a in the completion cycle: no overrun, valid stays
    do_reset();
    send_frame(4'hA, 4'h3);
    ack_b_pulse();
    send_frame(4'h5, 4'hC, 1'b0, 1'b1);
    idle(2);
    #1;
    chk("ack_overrun", 32'(bus.overrun), 32'b00);
    chk("ack_valid_a", 32'(bus.valid_a), 32'(1));
    chk("ack_out_a", 32'(bus.out_a), 32'h5);

    // Async reset in the middle of RECV_B, between clock edges
    do_reset();
    send_bit(1'b0, 1'b1, 1'b0);
    t0 = last_edge;
    push(0, 4'hA, t0 + 3);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    #2;
    chk("pre_rst_sel", 32'(bus.sel), 32'(1));
    chk("pre_rst_valid_a", 32'(bus.valid_a), 32'(1));
    reset = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    idle(2);
    #1;
    chk("nosof_valid_a", 32'(bus.valid_a), 32'(0));
    chk("nosof_sel", 32'(bus.sel), 32'(0));
    send_frame(4'h1, 4'h2);
    idle(2);
    #1;
    chk("post_rst_valid_b", 32'(bus.valid_b), 32'(1));

    chk("qa_drained_end", 32'(qa.size()), 32'(0));
    chk("qb_drained_end", 32'(qb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
